// File: rtl/seq_multiplier.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | seq_multiplier: unsigned shift-and-add multiplier, WIDTH cycles per job   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_acc_sum;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_count;
  logic                 w_last;

  assign w_last    = (r_count == CNT_W'(WIDTH - 1));
  assign w_acc_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Status flags decode straight from state so reset clears them at once.
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      product_lo <= '0;
      product_hi <= '0;
      ovf        <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        RUN: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CNT_W'(1);
          // Result registers only move on the final iteration.
          if (w_last) begin
            {product_hi, product_lo} <= w_acc_sum;
            ovf                      <= |w_acc_sum[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply; sampled on a rising clk edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned multiplicand, sampled with start.
REQ-006 The block SHALL have port b, input, WIDTH bits: unsigned multiplier, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port product_lo, output, WIDTH bits: low half of the registered product; this is the per-bit result consumed by the ALU result-select mux slices.
REQ-010 The block SHALL have port product_hi, output, WIDTH bits: high half of the registered product.
REQ-011 The block SHALL have port ovf, output, 1 bit: high when product_hi is nonzero.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at an edge SHALL latch a into a 2*WIDTH multiplicand register (zero-extended), latch b into a WIDTH multiplier register, clear the 2*WIDTH accumulator and the iteration counter, and enter RUN.
REQ-014 In IDLE, start=0 SHALL leave all registers unchanged.
REQ-015 Each RUN edge SHALL add the multiplicand to the accumulator when multiplier bit 0 is 1 (2*WIDTH-bit add, carry out discarded), then shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter.
REQ-016 The counter SHALL be wide enough to count WIDTH iterations.
REQ-017 RUN SHALL perform exactly WIDTH iterations, with no early termination for zero operands.
REQ-018 The edge performing the final iteration SHALL load {product_hi, product_lo} with the final accumulator value, load ovf with (final high half != 0), and enter DONE.
REQ-019 Latency SHALL be fixed: with start accepted at edge N, done SHALL be high in the cycle following edge N+WIDTH.
REQ-020 busy SHALL be 1 exactly while the state is RUN.
REQ-021 done SHALL be 1 exactly while the state is DONE, and DONE SHALL return to IDLE on the next edge unconditionally.
REQ-022 start SHALL be ignored in RUN and in DONE, with no restart and no effect on operands.
REQ-023 A start held high through DONE SHALL be accepted on the first edge in IDLE.
REQ-024 product_lo, product_hi and ovf SHALL change only at the completion edge, and SHALL hold the last result through IDLE and through a subsequent RUN.
REQ-025 Changes on a and b after the accepting edge SHALL not affect the result.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for clk, force state to IDLE and clear busy, done, ovf, product_lo, product_hi, the accumulator, the operand registers and the counter to 0.
REQ-027 A reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and the outputs SHALL read 0.
REQ-028 After reset deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-029 The bench SHALL check a=3, b=5, start pulse -> busy high for 32 cycles; done pulse in the cycle after edge N+32; product_lo=15, product_hi=0, ovf=0.
REQ-030 The bench SHALL check a=0xFFFFFFFF, b=0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001, ovf=1.
REQ-031 The bench SHALL check a start pulse with a=7, b=9 at RUN cycle 10 of a 3x5 job -> ignored; result 15; done at the original cycle count.
REQ-032 The bench SHALL check reset asserted between clock edges at RUN cycle 16 -> busy=0 and outputs 0 immediately; no done follows; a new 6x7 job then gives 42.
REQ-033 The bench SHALL check start held high continuously with a=2, b=0x80000000 -> first result product_hi=1, product_lo=0, ovf=1; the next job is accepted on the edge after done falls, giving a done every 34 cycles.
REQ-034 The bench SHALL check a=0, b=0x12345678 -> full 32-cycle latency; product=0; ovf=0; the prior result holds until the completion edge.
